// File: rtl/fp_align_swap_pipe_if.sv
// Handshake bundle for the FP adder front end: operand-pair input channel and
// aligned-result output channel.
interface fp_align_swap_pipe_if #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
);
    localparam int unsigned W = 1 + EXP_W + FRAC_W;

    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      op_a;
    logic [W-1:0]      op_b;
    logic              out_valid;
    logic              out_ready;
    logic              swapped;
    logic              big_sign;
    logic              eff_sub;
    logic [EXP_W-1:0]  big_exp;
    logic [EXP_W-1:0]  exp_diff;
    logic [FRAC_W:0]   big_sig;
    logic [FRAC_W+3:0] small_sig_al;
    logic              special;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, swapped, big_sign, eff_sub, big_exp, exp_diff,
               big_sig, small_sig_al, special
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, swapped, big_sign, eff_sub, big_exp, exp_diff,
               big_sig, small_sig_al, special
    );
endinterface

// File: rtl/fp_align_swap_pipe.sv
// FP adder front end: stage 1 orders operands by magnitude and swaps, stage 2
// right-aligns the smaller significand with guard/round/sticky bits.
module fp_align_swap_pipe #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic                clk,
    input  logic                rst,
    fp_align_swap_pipe_if.slave bus_io
);
    localparam int unsigned W  = 1 + EXP_W + FRAC_W;
    localparam int unsigned AW = FRAC_W + 4;

    logic             s1_adv, s2_adv;
    logic             swap;
    logic [W-1:0]     big_op, small_op;
    logic [EXP_W-1:0] big_exp_raw, small_exp_raw, big_exp_eff, small_exp_eff;
    logic [AW-1:0]    ext, mask, al;

    logic              s1_valid_q, s1_valid_d, s1_swapped_q, s1_swapped_d;
    logic              s1_big_sign_q, s1_big_sign_d, s1_eff_sub_q, s1_eff_sub_d;
    logic              s1_special_q, s1_special_d;
    logic [EXP_W-1:0]  s1_big_exp_q, s1_big_exp_d, s1_exp_diff_q, s1_exp_diff_d;
    logic [FRAC_W:0]   s1_big_sig_q, s1_big_sig_d, s1_small_sig_q, s1_small_sig_d;

    logic              s2_valid_q, s2_valid_d, s2_swapped_q, s2_swapped_d;
    logic              s2_big_sign_q, s2_big_sign_d, s2_eff_sub_q, s2_eff_sub_d;
    logic              s2_special_q, s2_special_d;
    logic [EXP_W-1:0]  s2_big_exp_q, s2_big_exp_d, s2_exp_diff_q, s2_exp_diff_d;
    logic [FRAC_W:0]   s2_big_sig_q, s2_big_sig_d;
    logic [AW-1:0]     s2_al_q, s2_al_d;

    assign s2_adv = !s2_valid_q || bus_io.out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;

    // Magnitude compare on raw {exp, frac}; ties keep A as the big operand.
    always_comb begin
        swap          = bus_io.op_b[W-2:0] > bus_io.op_a[W-2:0];
        big_op        = swap ? bus_io.op_b : bus_io.op_a;
        small_op      = swap ? bus_io.op_a : bus_io.op_b;
        big_exp_raw   = big_op[W-2 -: EXP_W];
        small_exp_raw = small_op[W-2 -: EXP_W];
        big_exp_eff   = (big_exp_raw == '0) ? EXP_W'(1) : big_exp_raw;
        small_exp_eff = (small_exp_raw == '0) ? EXP_W'(1) : small_exp_raw;
    end

    always_comb begin
        s1_valid_d     = s1_valid_q;
        s1_swapped_d   = s1_swapped_q;
        s1_big_sign_d  = s1_big_sign_q;
        s1_eff_sub_d   = s1_eff_sub_q;
        s1_special_d   = s1_special_q;
        s1_big_exp_d   = s1_big_exp_q;
        s1_exp_diff_d  = s1_exp_diff_q;
        s1_big_sig_d   = s1_big_sig_q;
        s1_small_sig_d = s1_small_sig_q;
        if (s1_adv) begin
            s1_valid_d = bus_io.in_valid;
            if (bus_io.in_valid) begin
                s1_swapped_d   = swap;
                s1_big_sign_d  = big_op[W-1];
                s1_eff_sub_d   = bus_io.op_a[W-1] ^ bus_io.op_b[W-1];
                s1_special_d   = (&bus_io.op_a[W-2 -: EXP_W]) | (&bus_io.op_b[W-2 -: EXP_W]);
                s1_big_exp_d   = big_exp_eff;
                s1_exp_diff_d  = big_exp_eff - small_exp_eff;
                s1_big_sig_d   = {big_exp_raw != '0, big_op[FRAC_W-1:0]};
                s1_small_sig_d = {small_exp_raw != '0, small_op[FRAC_W-1:0]};
            end
        end
    end

    // Shifting past the whole extended field collapses everything into sticky.
    always_comb begin
        ext  = {s1_small_sig_q, 3'b000};
        mask = ~({AW{1'b1}} << s1_exp_diff_q);
        if (32'(s1_exp_diff_q) >= AW) begin
            al = {{(AW-1){1'b0}}, |s1_small_sig_q};
        end else begin
            al = (ext >> s1_exp_diff_q) | {{(AW-1){1'b0}}, |(ext & mask)};
        end
    end

    always_comb begin
        s2_valid_d    = s2_valid_q;
        s2_swapped_d  = s2_swapped_q;
        s2_big_sign_d = s2_big_sign_q;
        s2_eff_sub_d  = s2_eff_sub_q;
        s2_special_d  = s2_special_q;
        s2_big_exp_d  = s2_big_exp_q;
        s2_exp_diff_d = s2_exp_diff_q;
        s2_big_sig_d  = s2_big_sig_q;
        s2_al_d       = s2_al_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_swapped_d  = s1_swapped_q;
                s2_big_sign_d = s1_big_sign_q;
                s2_eff_sub_d  = s1_eff_sub_q;
                s2_special_d  = s1_special_q;
                s2_big_exp_d  = s1_big_exp_q;
                s2_exp_diff_d = s1_exp_diff_q;
                s2_big_sig_d  = s1_big_sig_q;
                s2_al_d       = al;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_swapped_q   <= 1'b0;
            s1_big_sign_q  <= 1'b0;
            s1_eff_sub_q   <= 1'b0;
            s1_special_q   <= 1'b0;
            s1_big_exp_q   <= '0;
            s1_exp_diff_q  <= '0;
            s1_big_sig_q   <= '0;
            s1_small_sig_q <= '0;
            s2_valid_q     <= 1'b0;
            s2_swapped_q   <= 1'b0;
            s2_big_sign_q  <= 1'b0;
            s2_eff_sub_q   <= 1'b0;
            s2_special_q   <= 1'b0;
            s2_big_exp_q   <= '0;
            s2_exp_diff_q  <= '0;
            s2_big_sig_q   <= '0;
            s2_al_q        <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_swapped_q   <= s1_swapped_d;
            s1_big_sign_q  <= s1_big_sign_d;
            s1_eff_sub_q   <= s1_eff_sub_d;
            s1_special_q   <= s1_special_d;
            s1_big_exp_q   <= s1_big_exp_d;
            s1_exp_diff_q  <= s1_exp_diff_d;
            s1_big_sig_q   <= s1_big_sig_d;
            s1_small_sig_q <= s1_small_sig_d;
            s2_valid_q     <= s2_valid_d;
            s2_swapped_q   <= s2_swapped_d;
            s2_big_sign_q  <= s2_big_sign_d;
            s2_eff_sub_q   <= s2_eff_sub_d;
            s2_special_q   <= s2_special_d;
            s2_big_exp_q   <= s2_big_exp_d;
            s2_exp_diff_q  <= s2_exp_diff_d;
            s2_big_sig_q   <= s2_big_sig_d;
            s2_al_q        <= s2_al_d;
        end
    end

    assign bus_io.in_ready     = s1_adv;
    assign bus_io.out_valid    = s2_valid_q;
    assign bus_io.swapped      = s2_swapped_q;
    assign bus_io.big_sign     = s2_big_sign_q;
    assign bus_io.eff_sub      = s2_eff_sub_q;
    assign bus_io.special      = s2_special_q;
    assign bus_io.big_exp      = s2_big_exp_q;
    assign bus_io.exp_diff     = s2_exp_diff_q;
    assign bus_io.big_sig      = s2_big_sig_q;
    assign bus_io.small_sig_al = s2_al_q;
endmodule
